// File: rtl/scanline_fetch_if.sv
// PSRAM read port between scanline_fetch (master) and the PSRAM controller (slave).
interface scanline_fetch_if;
  logic        psram_stb;
  logic        psram_we;
  logic [23:0] psram_addr;
  logic        psram_busy;
  logic        psram_done;
  logic [15:0] psram_dout;

  modport master (
    output psram_stb, psram_we, psram_addr,
    input  psram_busy, psram_done, psram_dout
  );

  modport slave (
    input  psram_stb, psram_we, psram_addr,
    output psram_busy, psram_done, psram_dout
  );
endinterface

// File: rtl/scanline_fetch.sv
// Ping-pong line-buffer fetch from PSRAM with 2x horizontal/vertical pixel doubling for 640x480.
// Optional macro SCANLINE_FETCH_UNDERRUN_EN: sticky overrun flag, late-trigger restart, 12'hF0F for unfetched pixels.
module scanline_fetch #(
  parameter int LINE_PIXELS = 320,
  parameter int LINE_STRIDE = 640
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [8:0]       i_scan_row,
  input  logic [9:0]       i_scan_column,
  input  logic             i_blank,
  input  logic [23:0]      i_base_addr,
  scanline_fetch_if.master psram,
  output logic [11:0]      o_color,
  output logic             o_underrun
);
  localparam int            IW       = $clog2(LINE_PIXELS);
  localparam logic [IW-1:0] LAST_IDX = IW'(LINE_PIXELS - 1);
  localparam logic [23:0]   STRIDE   = 24'(LINE_STRIDE);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [23:0]   start_q, start_d;
  logic          sel_q, sel_d;
  logic [11:0]   color_q, color_d;

  logic [11:0] buf0 [LINE_PIXELS];
  logic [11:0] buf1 [LINE_PIXELS];

  logic          at_eol, frame_trig, line_trig, trig, trig_sel;
  logic [23:0]   trig_addr, prev_start;
  logic          wr_en, launch, launch_sel;
  logic [23:0]   launch_addr;
  logic          pend_now, pend_sel_now, pix_unfilled;
  logic [23:0]   pend_addr_now;
  logic [IW-1:0] rd_idx;
  logic          rd_sel;
  logic [11:0]   rd_pix;
  logic [3:0]    dout_unused;

  assign at_eol     = (i_scan_column == 10'd639);
  assign frame_trig = at_eol && (i_scan_row == 9'd479);
  assign line_trig  = at_eol && i_scan_row[0] && (i_scan_row < 9'd479);
  assign trig       = frame_trig || line_trig;
  // Triggers only occur on odd rows, where bit 0 of (row+1)/2 equals ~row[1]; row 479 yields buf0.
  assign trig_sel   = ~i_scan_row[1];
  assign trig_addr  = frame_trig ? i_base_addr : prev_start + STRIDE;

`ifdef SCANLINE_FETCH_UNDERRUN_EN
  logic          pend_q, pend_d;
  logic [23:0]   pend_addr_q, pend_addr_d;
  logic          pend_sel_q, pend_sel_d;
  logic          underrun_q, underrun_d;
  logic [IW:0]   fill0_q, fill0_d, fill1_q, fill1_d;

  assign prev_start    = pend_q ? pend_addr_q : start_q;
  assign pend_now      = pend_q;
  assign pend_addr_now = pend_addr_q;
  assign pend_sel_now  = pend_sel_q;
  assign pix_unfilled  = ({1'b0, rd_idx} >= (rd_sel ? fill1_q : fill0_q));
  assign o_underrun    = underrun_q;

  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_sel_d  = pend_sel_q;
    underrun_d  = underrun_q;
    fill0_d     = fill0_q;
    fill1_d     = fill1_q;
    if (launch) begin
      pend_d = 1'b0;
      if (launch_sel) fill1_d = '0;
      else            fill0_d = '0;
    end
    if (trig && (state_q != S_IDLE)) begin
      underrun_d  = 1'b1;
      pend_d      = 1'b1;
      pend_addr_d = trig_addr;
      pend_sel_d  = trig_sel;
    end
    if (wr_en) begin
      if (sel_q) fill1_d = {1'b0, idx_q} + 1'b1;
      else       fill0_d = {1'b0, idx_q} + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_sel_q  <= 1'b0;
      underrun_q  <= 1'b0;
      fill0_q     <= '0;
      fill1_q     <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_sel_q  <= pend_sel_d;
      underrun_q  <= underrun_d;
      fill0_q     <= fill0_d;
      fill1_q     <= fill1_d;
    end
  end
`else
  assign prev_start    = start_q;
  assign pend_now      = 1'b0;
  assign pend_addr_now = start_q;
  assign pend_sel_now  = sel_q;
  assign pix_unfilled  = 1'b0;
  assign o_underrun    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_en       = 1'b0;
    launch      = 1'b0;
    launch_addr = trig_addr;
    launch_sel  = trig_sel;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          launch = 1'b1;
        end else if (pend_now) begin
          launch      = 1'b1;
          launch_addr = pend_addr_now;
          launch_sel  = pend_sel_now;
        end
      end
      S_ISSUE: begin
        if (psram.psram_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (psram.psram_done) begin
          // A pending late trigger abandons the old line; its in-flight word is dropped.
          if (pend_now) begin
            launch      = 1'b1;
            launch_addr = pend_addr_now;
            launch_sel  = pend_sel_now;
          end else begin
            wr_en = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = S_IDLE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_ISSUE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      state_d = S_ISSUE;
      idx_d   = '0;
    end
  end

  assign start_d = launch ? launch_addr : start_q;
  assign sel_d   = launch ? launch_sel : sel_q;

  assign psram.psram_stb  = (state_q == S_ISSUE);
  assign psram.psram_we   = 1'b0;
  assign psram.psram_addr = start_q + {{(23 - IW){1'b0}}, idx_q, 1'b0};
  assign dout_unused      = psram.psram_dout[15:12];

  assign rd_idx = IW'(i_scan_column >> 1);
  assign rd_sel = i_scan_row[1];

  always_comb begin
    rd_pix  = rd_sel ? buf1[rd_idx] : buf0[rd_idx];
    color_d = rd_pix;
    if (pix_unfilled) color_d = 12'hF0F;
    if (i_blank)      color_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      if (sel_q) buf1[idx_q] <= psram.psram_dout[11:0];
      else       buf0[idx_q] <= psram.psram_dout[11:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      start_q <= '0;
      sel_q   <= 1'b0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      sel_q   <= sel_d;
      color_q <= color_d;
    end
  end

  assign o_color = color_q;
endmodule

// File: tb/tb_scanline_fetch.sv
// Bench for scanline_fetch: fixed vector table, hand sequences and randomized lines against a PSRAM/display model.
`timescale 1ns/1ps
module tb_scanline_fetch;
  localparam int LP = 320;
  localparam int LS = 640;

  typedef struct {
    int          row;
    int          col;
    bit          blank;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  row;
  logic [9:0]  col;
  logic        blank;
  logic [23:0] base;
  logic [11:0] color;
  logic        underrun;

  scanline_fetch_if psram_if();

  scanline_fetch #(.LINE_PIXELS(LP), .LINE_STRIDE(LS)) dut (
    .i_clk(clk), .i_rst(rst), .i_scan_row(row), .i_scan_column(col),
    .i_blank(blank), .i_base_addr(base), .psram(psram_if),
    .o_color(color), .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 2;
  logic [11:0] seed  = '0;
  logic [23:0] req_addr;
  int          cnt;
  logic [23:0] req_log[$];

  // Memory contents: byte address a holds word index a/2, xor-scrambled by seed, top nibble 4'hF.
  function automatic logic [15:0] memword(input logic [23:0] a, input logic [11:0] s);
    return {4'hF, a[12:1] ^ s};
  endfunction

  function automatic logic [11:0] ref_pix(input int r, input int c, input bit b,
                                          input logic [23:0] fb, input logic [11:0] s);
    logic [23:0] a;
    logic [15:0] w;
    if (b) return 12'h000;
    a = fb + 24'(LS * (r / 2)) + 24'(2 * (c / 2));
    w = memword(a, s);
    return w[11:0];
  endfunction

  // PSRAM controller model: busy the cycle after an accepted strobe, done lat clocks after busy.
  always @(posedge clk) begin
    if (rst) begin
      psram_if.psram_busy <= 1'b0;
      psram_if.psram_done <= 1'b0;
      psram_if.psram_dout <= '0;
      cnt <= 0;
    end else begin
      psram_if.psram_done <= 1'b0;
      if (psram_if.psram_busy) begin
        if (cnt == lat - 1) begin
          psram_if.psram_busy <= 1'b0;
          psram_if.psram_done <= 1'b1;
          psram_if.psram_dout <= memword(req_addr, seed);
        end
        cnt <= cnt + 1;
      end else if (psram_if.psram_stb) begin
        psram_if.psram_busy <= 1'b1;
        cnt      <= 0;
        req_addr <= psram_if.psram_addr;
        req_log.push_back(psram_if.psram_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    row   = 9'd500;
    col   = 10'd700;
    blank = 1'b1;
  endtask

  task automatic trigger(input logic [8:0] r, input logic [23:0] exp_addr, input string name);
    row = r; col = 10'd639; blank = 1'b0;
    tick();
    park();
    chk({name, " stb"}, 32'(psram_if.psram_stb), 32'd1);
    chk({name, " addr"}, 32'(psram_if.psram_addr), 32'(exp_addr));
  endtask

  task automatic pix(input string name, input int r, input int c, input bit b, input logic [11:0] exp);
    row = 9'(r); col = 10'(c); blank = b;
    tick();
    park();
    chk(name, 32'(color), 32'(exp));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 16 && n < budget) begin
      tick();
      n++;
      if (psram_if.psram_stb || psram_if.psram_busy || psram_if.psram_done) quiet = 0;
      else quiet++;
    end
    total++;
    if (quiet < 16) begin
      bad++;
      $display("FAIL %s: fetch not idle within %0d cycles", name, budget);
    end
  endtask

  task automatic chk_line(input string name, input logic [23:0] start);
    int errs = 0;
    logic [23:0] e;
    total++;
    if (req_log.size() != LP) errs++;
    else for (int k = 0; k < LP; k++) begin
      e = start + 24'(2 * k);
      if (req_log[k] !== e) errs++;
    end
    if (errs != 0) begin
      bad++;
      $display("FAIL %s: requests=%0d errors=%0d want %0d requests from %h",
               name, req_log.size(), errs, LP, start);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec [15];
    int   n;
    int   r, c;
    bit   b;
    vec[0]  = '{0,   0,   1'b0, 12'h000};
    vec[1]  = '{0,   1,   1'b0, 12'h000};
    vec[2]  = '{0,   2,   1'b0, 12'h001};
    vec[3]  = '{0,   3,   1'b0, 12'h001};
    vec[4]  = '{0,   255, 1'b0, 12'h07F};
    vec[5]  = '{0,   639, 1'b0, 12'h13F};
    vec[6]  = '{1,   2,   1'b0, 12'h001};
    vec[7]  = '{1,   638, 1'b0, 12'h13F};
    vec[8]  = '{0,   100, 1'b1, 12'h000};
    vec[9]  = '{1,   50,  1'b1, 12'h000};
    vec[10] = '{2,   0,   1'b0, 12'h140};
    vec[11] = '{2,   1,   1'b0, 12'h140};
    vec[12] = '{3,   10,  1'b0, 12'h145};
    vec[13] = '{2,   638, 1'b0, 12'h27F};
    vec[14] = '{3,   200, 1'b1, 12'h000};

    // Reset held while the frame trigger position is presented.
    row = 9'd479; col = 10'd639; blank = 1'b0; base = 24'h0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset stb",      32'(psram_if.psram_stb),  32'd0);
    chk("reset addr",     32'(psram_if.psram_addr), 32'd0);
    chk("reset we",       32'(psram_if.psram_we),   32'd0);
    chk("reset color",    32'(color),               32'd0);
    chk("reset underrun", 32'(underrun),            32'd0);
    rst = 1'b0;
    park();
    repeat (4) tick();
    chk("idle stb", 32'(psram_if.psram_stb), 32'd0);

    // Known pattern: word k = 16'hF000 | k, base 0.
    seed = '0; lat = 2; base = 24'h0;
    req_log.delete();
    trigger(9'd479, 24'h0, "frame0");
    wait_idle(3000, "frame0 fetch");
    chk_line("frame0 addrs", 24'h0);
    for (int i = 0; i < 15; i++)
      if (vec[i].row < 2) pix($sformatf("vec%0d", i), vec[i].row, vec[i].col, vec[i].blank, vec[i].exp);
    req_log.delete();
    trigger(9'd1, 24'd640, "line1");
    wait_idle(3000, "line1 fetch");
    chk_line("line1 addrs", 24'd640);
    for (int i = 0; i < 15; i++)
      if (vec[i].row >= 2) pix($sformatf("vec%0d", i), vec[i].row, vec[i].col, vec[i].blank, vec[i].exp);
    chk("we stays 0", 32'(psram_if.psram_we), 32'd0);

    // Randomized base and contents.
    seed = 12'($urandom);
    base = 24'($urandom) & 24'hFFFFFE;
    req_log.delete();
    trigger(9'd479, base, "rand frame");
    wait_idle(3000, "rand frame fetch");
    chk_line("rand line0 addrs", base);
    req_log.delete();
    trigger(9'd1, base + 24'd640, "rand line1");
    wait_idle(3000, "rand line1 fetch");
    chk_line("rand line1 addrs", base + 24'd640);
    for (int i = 0; i < 100; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 639);
      b = ($urandom_range(0, 7) == 0);
      if ((r % 2 == 1) && c == 639) c = 638;
      pix($sformatf("rand pix r%0d c%0d b%0d", r, c, b), r, c, b, ref_pix(r, c, b, base, seed));
    end

    // Address wrap at the top of the 24-bit space.
    base = 24'hFFFFFE;
    req_log.delete();
    trigger(9'd479, 24'hFFFFFE, "wrap frame");
    wait_idle(3000, "wrap fetch");
    chk("wrap addr1", (req_log.size() > 1) ? 32'(req_log[1]) : 32'hDEADBEEF, 32'h0);
    chk_line("wrap addrs", 24'hFFFFFE);
    pix("wrap pix", 0, 5, 1'b0, ref_pix(0, 5, 1'b0, base, seed));

    // Reset in the middle of a fetch.
    base = 24'h0; seed = '0;
    req_log.delete();
    trigger(9'd479, 24'h0, "mid frame");
    repeat (41) tick();
    n = 0;
    while (!psram_if.psram_stb && n < 10) begin tick(); n++; end
    chk("mid stb before rst", 32'(psram_if.psram_stb), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid rst stb", 32'(psram_if.psram_stb), 32'd0);
    chk("mid rst addr", 32'(psram_if.psram_addr), 32'd0);
    rst = 1'b0;
    n = 0;
    repeat (30) begin tick(); if (psram_if.psram_stb) n++; end
    chk("post rst idle", 32'(n), 32'd0);
    chk("no underrun yet", 32'(underrun), 32'd0);

    // Slow controller: line 1 trigger arrives while line 0 is still fetching.
    lat = 8; base = 24'h001000; seed = 12'h5A5;
    req_log.delete();
    trigger(9'd479, base, "slow frame");
    repeat (1600) tick();
    row = 9'd1; col = 10'd639; blank = 1'b0;
    tick();
    park();
`ifdef SCANLINE_FETCH_UNDERRUN_EN
    chk("underrun set", 32'(underrun), 32'd1);
    wait_idle(8000, "slow overrun fetch");
    n = req_log.size();
    chk("overrun line1 first", (n >= LP) ? 32'(req_log[n - LP]) : 32'hDEADBEEF, 32'(base + 24'd640));
    chk("overrun line1 last", (n >= 1) ? 32'(req_log[n - 1]) : 32'hDEADBEEF, 32'(base + 24'd640 + 24'd638));
    pix("unfilled pix", 0, 639, 1'b0, 12'hF0F);
    pix("filled pix", 0, 0, 1'b0, ref_pix(0, 0, 1'b0, base, seed));
    pix("line1 after overrun", 2, 639, 1'b0, ref_pix(2, 639, 1'b0, base, seed));
    chk("underrun sticky", 32'(underrun), 32'd1);
`else
    wait_idle(8000, "slow fetch");
    chk("no underrun", 32'(underrun), 32'd0);
    chk_line("slow in order", base);
    pix("slow line0 end", 0, 639, 1'b0, ref_pix(0, 639, 1'b0, base, seed));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scanline_fetch.md
# scanline_fetch

Pixel-fetch stage between the PSRAM controller and the VGA colour output mux. It reads one 320-pixel source line at a time from PSRAM into a ping-pong pair of line buffers while the other buffer is being displayed. It then supplies a 12-bit RGB colour per pixel clock, doubling each source pixel horizontally and each source line vertically, to fill the 640x480 active area.

## Interface
Parameters:
- LINE_PIXELS, 320, source pixels per line (one 16-bit PSRAM word each)
- LINE_STRIDE, 640, byte distance between consecutive source lines in PSRAM

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- i_clk  in  1  pixel clock, same clock as the VGA timing core and PSRAM controller
- i_rst  in  1  reset
- i_scan_row  in  9  current display row (0..479 active)
- i_scan_column  in  10  current display column (0..639 active)
- i_blank  in  1  high outside the active area
- i_base_addr  in  24  frame base byte address, sampled once per frame
- o_psram_stb  out  1  read request strobe to the PSRAM controller
- o_psram_we  out  1  write enable, constant 0
- o_psram_addr  out  24  request byte address
- i_psram_busy  in  1  controller busy
- i_psram_done  in  1  one-cycle pulse, read data valid
- i_psram_dout  in  16  read data; bits 11:0 are RGB444, bits 15:12 are ignored
- o_color  out  12  pixel colour (R 11:8, G 7:4, B 3:0)
- o_underrun  out  1  sticky fetch-overrun flag

## Operation
- Buffers: buf0 and buf1, each LINE_PIXELS x 12 bits. Source line s is stored in buf[s[0]].
- Fetch triggers are evaluated when i_scan_column == 639:
  - i_scan_row == 479: latch fr_base <= i_base_addr, then fetch source line 0 into buf0 from address frame base.
  - i_scan_row odd and < 479: fetch source line s = (row+1)/2 from the previous line start + LINE_STRIDE.
- Fetch FSM:
  - IDLE: on a trigger, load the line start address, set idx=0, go to ISSUE.
  - ISSUE: drive o_psram_stb=1 and o_psram_addr = line start + 2*idx. When i_psram_busy==1, drop stb and go to WAIT.
  - WAIT: on i_psram_done, write i_psram_dout[11:0] to buf[s[0]][idx]. If idx == LINE_PIXELS-1, set fill[s[0]] = LINE_PIXELS and go to IDLE; otherwise increment idx and fill, then go to ISSUE.
  - i_psram_done seen in IDLE or ISSUE is ignored.
- Display: source line = row>>1, buffer = row[1], pixel index = column>>1. Read buf[row[1]][column>>1].
- Address arithmetic: 24-bit, wraps modulo 2^24 with no error.
- Reset values: o_psram_stb=0, o_psram_we=0, o_psram_addr=0, o_color=0, o_underrun=0, FSM=IDLE, idx=0, fill=0. Buffer contents are not cleared.
- Reset mid-fetch: stb is low on the next cycle and the FSM returns to IDLE. The PSRAM controller shares the same reset.

## Timing
- o_color is registered with 1-cycle latency: the value at cycle t+1 reflects the row/column/i_blank sampled at t. It is 0 when i_blank was high at t.
- The fetch budget is 2 display lines (1600 clocks), so each word must complete within 5 clocks on average.
- The first ISSUE cycle is the cycle after the trigger.
- Minimum spacing between requests is 3 clocks (ISSUE, WAIT, done).
- Display reads and fetch writes never target the same buffer in a correctly timed frame; no bypass is needed.

## Configuration
- SCANLINE_FETCH_UNDERRUN_EN defined: behaviour when a trigger arrives while the FSM is not IDLE:
  - o_underrun is set (sticky until reset).
  - The FSM finishes the outstanding transaction, discarding its data if that transaction is in WAIT, then starts the new line.
  - Pixels with index >= fill of the displayed buffer are output as 12'hF0F.
- Not defined: o_underrun is constant 0, a trigger while busy is dropped, the current fetch completes, and the fill check is omitted.

## Test plan
- Reset, then release with PSRAM model done 2 clocks after busy -> stb low during reset; after the row 479/col 639 trigger, the first request has addr = i_base_addr.
- Memory word k = 16'hF000|k[11:0], base 0 -> on row 0, col 2k and col 2k+1 give o_color = k one cycle later; rows 0 and 1 are identical.
- Base 24'hFFFFFE -> second request address is 24'h000000 (wrap).
- Request/data addressing -> line 1 fetch starts at row 1/col 639 with addr base+640; rows 2/3 display buf1.
- i_blank high -> o_color = 0 on the next cycle regardless of buffer contents.
- Slow model (done 8 clocks after busy), with SCANLINE_FETCH_UNDERRUN_EN -> o_underrun = 1 and unfilled pixels show 12'hF0F. Without the macro -> o_underrun stays 0 and no request is issued out of order.
